// File: rtl/jk_counter_pkg.sv
// Shared constants and helpers for the JK-flop based up/down counter.
package jk_counter_pkg;

  // Direction encoding on the dir input
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Boundary behaviour selected by the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Encoding of the J/K input pair driven into one cell
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  // Clamp a requested load value into the legal range 0..modulus-1.
  // Values at or above the modulus land on the top of the range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] modulus);
    logic [31:0] result;
    if (val >= modulus) begin
      result = modulus - 32'd1;
    end else begin
      result = val;
    end
    return result;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK bistable with an asynchronous active-low clear.
module jk_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic   q_reg;
  jk_op_e op;

  assign op = jk_op_e'({j, k});

  // Classic JK behaviour: hold, clear, set or toggle on the rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= 1'b0;
    end else begin
      case (op)
        JK_HOLD:   q_reg <= q_reg;
        JK_RESET:  q_reg <= 1'b0;
        JK_SET:    q_reg <= 1'b1;
        JK_TOGGLE: q_reg <= ~q_reg;
        default:   q_reg <= q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter whose state lives in a bank of JK cells.
// count and tc are delayed one clock behind the internal state q, with tc
// marking the first cycle in which count shows the result of a boundary step.
module jk_updown_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Highest legal state; also the terminal value when counting up
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic             SAT_EN = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             boundary;

  logic [WIDTH-1:0] count_reg;
  logic             event_reg;
  logic             tc_reg;

  // Next-state selection and per-bit J/K decode (load > en > hold)
  always_comb begin
    q_next       = q;
    boundary     = 1'b0;
    load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
    j_vec        = '0;
    k_vec        = '0;

    if (load) begin
      // Direct set/clear of every bit; never counts as a boundary event
      q_next = load_clamped;
      j_vec  = load_clamped;
      k_vec  = ~load_clamped;
    end else begin
      if (en) begin
        if (dir == DIR_UP) begin
          if (q == MAX_Q) begin
            boundary = 1'b1;
            q_next   = SAT_EN ? q : '0;
          end else begin
            q_next = q + 1'b1;
          end
        end else begin
          if (q == '0) begin
            boundary = 1'b1;
            q_next   = SAT_EN ? q : MAX_Q;
          end else begin
            q_next = q - 1'b1;
          end
        end
      end
      // Toggle exactly the bits that change; everything else holds
      j_vec = q ^ q_next;
      k_vec = q ^ q_next;
    end
  end

  // State bank: one JK cell per bit
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .j       (j_vec[gi]),
        .k       (k_vec[gi]),
        .q       (q[gi])
      );
    end
  endgenerate

  // Output pipeline: count trails q by one clock, tc trails the event by two
  // so that it lines up with the first cycle count shows the post-event value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      event_reg <= 1'b0;
      tc_reg    <= 1'b0;
    end else begin
      count_reg <= q;
      event_reg <= boundary;
      tc_reg    <= event_reg;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;

endmodule
